sha_word_window: RTL
====================

SHA_WORD_WINDOW -- requirements
Module: sha_word_window

Interface
REQ-001 SHALL have parameter WIDTH, default 32, word width per lane in bits.
REQ-002 SHALL have parameter LANES, default 3, number of independent parallel lanes.
REQ-003 SHALL have parameter DEPTH, default 16, window depth in words per lane; legal range 2..64.
REQ-004 SHALL have port CLK  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port RST  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port clear  input  1  synchronous flush of the window contents and fill state.
REQ-007 SHALL have port freeze  input  1  holds the window; blocks pushes.
REQ-008 SHALL have port in_valid  input  1  qualifies in_data.
REQ-009 SHALL have port in_ready  output  1  window can accept a push this cycle.
REQ-010 SHALL have port in_data  input  LANES*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH].
REQ-011 SHALL have port rd_idx  input  clog2(DEPTH)  tap select; 0 is the newest word, DEPTH-1 the oldest.
REQ-012 SHALL have port rd_data  output  LANES*WIDTH  registered tap rd_idx of every lane.
REQ-013 SHALL have port fill_cnt  output  clog2(DEPTH+1)  number of valid words per lane.
REQ-014 SHALL have port full  output  1  fill_cnt equals DEPTH.
REQ-015 SHALL have port parity_err  output  LANES  per-lane parity mismatch on rd_data; present only with SHA_WIN_PARITY_EN.

Function
REQ-016 SHALL accept a push when in_valid and in_ready are both high in the same cycle.
REQ-017 SHALL drive in_ready = !freeze && !clear, combinationally; it SHALL NOT depend on full.
REQ-018 On a push, every lane SHALL shift: tap i+1 takes tap i, tap 0 takes that lane's in_data word, and the oldest word is discarded.
REQ-019 Without a push, every tap SHALL hold its value.
REQ-020 SHALL implement states EMPTY (fill_cnt=0), FILL (0<fill_cnt<DEPTH) and FULL (fill_cnt=DEPTH).
REQ-021 State transitions on a push: EMPTY->FILL, FILL->FILL (or FILL->FULL when fill_cnt reaches DEPTH), FULL->FULL; fill_cnt saturates at DEPTH.
REQ-022 clear high SHALL zero all taps and fill_cnt and enter EMPTY next cycle; clear SHALL take priority over in_valid and freeze.
REQ-023 When freeze and in_valid are high together, the data SHALL be dropped and state SHALL be unchanged.
REQ-024 rd_data SHALL equal the tap addressed by rd_idx one cycle after rd_idx is presented, sampling post-update tap contents (1-cycle read latency).
REQ-025 rd_idx >= fill_cnt SHALL return zero words.
REQ-026 rd_idx >= DEPTH SHALL return zero words; this SHALL NOT be flagged as an error.
REQ-027 full SHALL be registered and SHALL be consistent with fill_cnt in the same cycle.

Reset
REQ-028 RST high at a rising edge SHALL zero all taps, rd_data, fill_cnt, full and parity_err and SHALL enter EMPTY.
REQ-029 RST SHALL override clear, freeze and in_valid.
REQ-030 A push coincident with RST SHALL be lost.
REQ-031 in_ready SHALL follow REQ-017 during reset; pushes during reset have no effect.

Configuration
REQ-032 With macro SHA_WIN_PARITY_EN defined, each stored word SHALL carry an even-parity bit computed at push time.
REQ-033 With SHA_WIN_PARITY_EN defined, parity_err[k] SHALL assert with rd_data when the read word of lane k mismatches its stored parity bit.
REQ-034 Without SHA_WIN_PARITY_EN, the parity_err port and all parity storage SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-035 Reset/idle: RST for 2 cycles, then idle -> fill_cnt=0, full=0, rd_data=0, in_ready=1.
REQ-036 Fill: WIDTH=32, LANES=3, DEPTH=16; push 16 words with lane k = 32'h1000_0000*k + n (n=0..15) -> full=1 after the 16th push; rd_idx=0 returns n=15 on all lanes; rd_idx=15 returns n=0.
REQ-037 Slide: from full, push n=16 -> fill_cnt stays 16; rd_idx=15 returns n=1; rd_idx=0 returns n=16.
REQ-038 Freeze: freeze=1 with in_valid=1 for 3 cycles -> in_ready=0, taps and fill_cnt unchanged.
REQ-039 Priority: clear and a push in the same cycle at fill_cnt=5 -> fill_cnt=0, rd_idx=0 returns 0; a mid-fill RST likewise empties the window.
REQ-040 Parity (SHA_WIN_PARITY_EN only): force-flip one stored bit of lane 1 tap 3, read rd_idx=3 -> parity_err=3'b010.

Source files
------------

// File: rtl/sha_word_window_if.sv
// sha_word_window_if: push handshake bundle (valid/ready plus one word per lane).
interface sha_word_window_if #(
    parameter int WIDTH = 32,
    parameter int LANES = 3
);
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*WIDTH-1:0] in_data;
    modport master (output in_valid, output in_data, input in_ready);
    modport slave (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/sha_word_window.sv
// sha_word_window: per-lane shifting word window with registered tap read.
// Optional per-word even parity with SHA_WIN_PARITY_EN.
module sha_word_window #(
    parameter int WIDTH = 32,
    parameter int LANES = 3,
    parameter int DEPTH = 16
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       clear,
    input  logic                       freeze,
    sha_word_window_if.slave           bus,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [LANES*WIDTH-1:0]     rd_data,
    output logic [$clog2(DEPTH+1)-1:0] fill_cnt,
    output logic                       full
`ifdef SHA_WIN_PARITY_EN
    ,
    output logic [LANES-1:0]           parity_err
`endif
);
    localparam int CW = $clog2(DEPTH + 1);
    typedef enum logic [1:0] {EMPTY, FILL, FULL} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic full_d, push, rd_ok;
    logic [WIDTH-1:0] taps [LANES][DEPTH];
    logic [WIDTH-1:0] tap_d [LANES][DEPTH];
    logic [LANES*WIDTH-1:0] rd_d;
    assign bus.in_ready = !freeze && !clear;
    assign push = bus.in_valid && bus.in_ready;
    assign fill_cnt = cnt_q;
    assign cnt_d = clear ? '0 : (push && state_q != FULL) ? cnt_q + CW'(1) : cnt_q;
    // Reads see the post-update window so a push and its readback share one edge.
    assign rd_ok = CW'(rd_idx) < cnt_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= EMPTY;
            cnt_q   <= '0;
            full    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            full    <= full_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear)
            state_d = EMPTY;
        else if (push)
            state_d = (state_q == FULL || cnt_q == CW'(DEPTH - 1)) ? FULL : FILL;
    end

    always_comb begin
        full_d = state_d == FULL;
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        for (genvar d = 0; d < DEPTH; d++) begin : g_tap
            if (d == 0) begin : g_head
                assign tap_d[k][d] = clear ? '0 : push ? bus.in_data[k*WIDTH +: WIDTH] : taps[k][d];
            end else begin : g_body
                assign tap_d[k][d] = clear ? '0 : push ? taps[k][d-1] : taps[k][d];
            end
        end
        assign rd_d[k*WIDTH +: WIDTH] = rd_ok ? tap_d[k][rd_idx] : '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            taps    <= '{default: '0};
            rd_data <= '0;
        end else begin
            taps    <= tap_d;
            rd_data <= rd_d;
        end
    end

`ifdef SHA_WIN_PARITY_EN
    logic par [LANES][DEPTH];
    logic par_d [LANES][DEPTH];
    logic [LANES-1:0] perr_d;
    for (genvar k = 0; k < LANES; k++) begin : g_plane
        for (genvar d = 0; d < DEPTH; d++) begin : g_ptap
            if (d == 0) begin : g_head
                assign par_d[k][d] = clear ? 1'b0 : push ? ^bus.in_data[k*WIDTH +: WIDTH] : par[k][d];
            end else begin : g_body
                assign par_d[k][d] = clear ? 1'b0 : push ? par[k][d-1] : par[k][d];
            end
        end
        assign perr_d[k] = rd_ok && ((^tap_d[k][rd_idx]) != par_d[k][rd_idx]);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            par        <= '{default: 1'b0};
            parity_err <= '0;
        end else begin
            par        <= par_d;
            parity_err <= perr_d;
        end
    end
`endif
endmodule
